// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared constants, state encoding and index helper for the
//            data-memory line responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int LINE_W    = 256;
    localparam int OFFSET_W  = 5;
    localparam int FN_ADDR_W = 64;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_ACK  = 2'd2
    } dm_state_t;

    // Caller keeps the low IDX_W bits; upper bits alias into the store.
    function automatic logic [FN_ADDR_W-1:0] line_index(input logic [FN_ADDR_W-1:0] addr);
        return addr >> OFFSET_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_responder_if
// Brief    : Cache <-> data-memory line request/ack bus.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_line_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              mem_enable_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_o;
    logic              busy_o;
    logic [31:0]       rd_cnt_o;
    logic [31:0]       wr_cnt_o;

    modport master (
        output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ack_o, busy_o, rd_cnt_o, wr_cnt_o
    );

    modport slave (
        input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ack_o, busy_o, rd_cnt_o, wr_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_array
// Brief    : Single-port synchronous line store, 2**IDX_W x LINE_W.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int IDX_W = 9
) (
    input  logic              clk_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              we_i,
    input  logic              re_i,
    output logic [LINE_W-1:0] data_o
);
    localparam int C_DEPTH = 2**IDX_W;

    logic [LINE_W-1:0] r_mem [C_DEPTH];
    logic [LINE_W-1:0] r_q;

    // No reset: store contents survive rst.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= data_i;
        end
        if (re_i) begin
            r_q <= r_mem[addr_i];
        end
    end

    assign data_o = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_line_responder
// Brief    : Fixed-latency line responder with one-cycle ack and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int IDX_W   = 9,
    parameter int LATENCY = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_line_responder_if.slave  bus
);
    localparam logic [7:0] C_LAT_LOAD = 8'(LATENCY - 1);

    dm_state_t         r_state;
    dm_state_t         w_state_nxt;
    logic [7:0]        r_lat_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;
    logic              r_rd_seen;
    logic [LINE_W-1:0] w_arr_q;
    logic [FN_ADDR_W-1:0] w_idx_full;
    logic              w_accept;
    logic              w_done;
    logic              w_we;
    logic              w_re;
    logic              w_unused;

    assign w_idx_full = line_index(FN_ADDR_W'(bus.mem_addr_i));
    assign w_unused   = ^w_idx_full[FN_ADDR_W-1:IDX_W];
    assign w_accept   = (r_state == DM_IDLE) && bus.mem_enable_i;
    assign w_done     = (r_state == DM_BUSY) && (r_lat_cnt == 8'd0);
    // A reset on the commit edge must not disturb the store.
    assign w_we       = w_done &&  r_write && !rst_i;
    assign w_re       = w_done && !r_write && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= DM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DM_IDLE: if (bus.mem_enable_i) w_state_nxt = DM_BUSY;
            DM_BUSY: if (r_lat_cnt == 8'd0) w_state_nxt = DM_ACK;
            DM_ACK:  w_state_nxt = DM_IDLE;
            default: w_state_nxt = DM_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ack_o  = (r_state == DM_ACK);
        bus.busy_o     = (r_state != DM_IDLE);
        bus.mem_data_o = r_rd_seen ? w_arr_q : '0;
        bus.rd_cnt_o   = r_rd_cnt;
        bus.wr_cnt_o   = r_wr_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lat_cnt <= 8'd0;
        end else if (w_accept) begin
            r_lat_cnt <= C_LAT_LOAD;
        end else if ((r_state == DM_BUSY) && (r_lat_cnt != 8'd0)) begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_idx   <= w_idx_full[IDX_W-1:0];
            r_write <= bus.mem_write_i;
            r_wdata <= bus.mem_data_i;
        end
    end

    // r_rd_seen masks the array output until the first read after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_cnt  <= 32'd0;
            r_wr_cnt  <= 32'd0;
            r_rd_seen <= 1'b0;
        end else if (w_done) begin
            if (r_write) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end else begin
                r_rd_cnt  <= r_rd_cnt + 32'd1;
                r_rd_seen <= 1'b1;
            end
        end
    end

    dmem_line_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i  (clk_i),
        .addr_i (r_idx),
        .data_i (r_wdata),
        .we_i   (w_we),
        .re_i   (w_re),
        .data_o (w_arr_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_line_responder
// Brief    : Self-checking bench for dmem_line_responder against a line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_line_responder;
    localparam int LATENCY = 10;
    localparam int IDX_W   = 9;
    localparam int LINES   = 2**IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [255:0] mdl_mem [LINES];
    bit           mdl_valid [LINES];
    logic [255:0] mdl_last;
    int unsigned  mdl_rd;
    int unsigned  mdl_wr;

    always #5 clk = ~clk;

    dmem_line_responder_if #(.ADDR_W(32)) u_if ();

    dmem_line_responder #(
        .IDX_W   (IDX_W),
        .LATENCY (LATENCY)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr / 32) % LINES);
    endfunction

    task automatic check_counts(input string name);
        checks++;
        if (u_if.rd_cnt_o !== mdl_rd || u_if.wr_cnt_o !== mdl_wr) begin
            failures++;
            $display("FAIL %s counts: rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     name, u_if.rd_cnt_o, u_if.wr_cnt_o, mdl_rd, mdl_wr);
        end
    endtask

    // Called at a negedge with the responder idle; returns at a negedge, idle.
    task automatic run_txn(input logic wr, input logic [31:0] addr,
                           input logic [255:0] data, input int drop_at,
                           input string name);
        int lat = 0;
        u_if.mem_enable_i = 1'b1;
        u_if.mem_write_i  = wr;
        u_if.mem_addr_i   = addr;
        u_if.mem_data_i   = data;
        @(posedge clk);
        for (int k = 1; k <= LATENCY + 20; k++) begin
            @(negedge clk);
            if (k == drop_at) u_if.mem_enable_i = 1'b0;
            if (u_if.mem_ack_o === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
        u_if.mem_enable_i = 1'b0;
        if (wr) begin
            mdl_mem[line_of(addr)]   = data;
            mdl_valid[line_of(addr)] = 1'b1;
            mdl_wr++;
        end else begin
            mdl_last = mdl_mem[line_of(addr)];
            mdl_rd++;
        end
        checks++;
        if (lat != LATENCY + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LATENCY + 1);
        end
        checks++;
        if (u_if.mem_data_o !== mdl_last) begin
            failures++;
            $display("FAIL %s data: got %h expected %h", name, u_if.mem_data_o, mdl_last);
        end
        check_counts(name);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (u_if.mem_ack_o !== 1'b0 || u_if.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_width: ack=%b busy=%b expected ack=0 busy=0",
                     name, u_if.mem_ack_o, u_if.busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_rd = 0; mdl_wr = 0; mdl_last = '0;
        @(negedge clk);
        checks++;
        if (u_if.mem_ack_o !== 1'b0 || u_if.busy_o !== 1'b0 || u_if.mem_data_o !== 256'd0) begin
            failures++;
            $display("FAIL reset outputs: ack=%b busy=%b data=%h expected 0 0 0",
                     u_if.mem_ack_o, u_if.busy_o, u_if.mem_data_o);
        end
        check_counts("reset");
    endtask

    task automatic test_write_read();
        logic [255:0] pat = {16{16'hA5A5}};
        run_txn(1'b1, 32'h0000_0040, pat, 0, "wr_0x40");
        run_txn(1'b0, 32'h0000_0040, '0, 0, "rd_0x40");
    endtask

    task automatic test_back_to_back();
        logic [255:0] d_wb   = {8{32'h1234_5678}};
        logic [255:0] d_fill = {8{32'hCAFE_F00D}};
        int gap = 0;
        run_txn(1'b1, 32'h0000_0800, d_fill, 0, "b2b_prefill");
        u_if.mem_enable_i = 1'b1;
        u_if.mem_write_i  = 1'b1;
        u_if.mem_addr_i   = 32'h0000_0400;
        u_if.mem_data_i   = d_wb;
        @(posedge clk);
        for (int k = 1; k <= LATENCY + 20; k++) begin
            @(negedge clk);
            if (u_if.mem_ack_o === 1'b1) break;
            @(posedge clk);
        end
        mdl_mem[line_of(32'h400)] = d_wb;
        mdl_wr++;
        // Cache drops write on seeing ack, keeps enable for the refill.
        u_if.mem_write_i = 1'b0;
        u_if.mem_addr_i  = 32'h0000_0800;
        u_if.mem_data_i  = '0;
        for (int j = 1; j <= 2 * LATENCY + 20; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.mem_ack_o === 1'b1) begin
                gap = j;
                break;
            end
        end
        u_if.mem_enable_i = 1'b0;
        mdl_last = mdl_mem[line_of(32'h800)];
        mdl_rd++;
        checks++;
        if (gap != LATENCY + 2) begin
            failures++;
            $display("FAIL b2b ack_gap: got %0d expected %0d", gap, LATENCY + 2);
        end
        checks++;
        if (u_if.mem_data_o !== mdl_last) begin
            failures++;
            $display("FAIL b2b refill_data: got %h expected %h", u_if.mem_data_o, mdl_last);
        end
        check_counts("b2b");
        @(posedge clk);
        @(negedge clk);
        run_txn(1'b0, 32'h0000_0400, '0, 0, "b2b_wb_readback");
    endtask

    task automatic test_alias();
        run_txn(1'b1, 32'h0000_0020, {4{64'hDEAD_BEEF_0BAD_F00D}}, 0, "alias_wr");
        run_txn(1'b0, 32'h0000_4020, '0, 0, "alias_rd");
    endtask

    task automatic test_enable_drop();
        run_txn(1'b1, 32'h0000_0100, {8{32'h5A5A_0F0F}}, 3, "drop_wr");
        run_txn(1'b0, 32'h0000_0100, '0, 0, "drop_rd");
    endtask

    task automatic test_reset_mid_write();
        bit saw_ack = 1'b0;
        run_txn(1'b1, 32'h0000_0200, {8{32'h1111_2222}}, 0, "rstmid_prior");
        u_if.mem_enable_i = 1'b1;
        u_if.mem_write_i  = 1'b1;
        u_if.mem_addr_i   = 32'h0000_0200;
        u_if.mem_data_i   = {8{32'h9999_8888}};
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (u_if.mem_ack_o === 1'b1) saw_ack = 1'b1;
            if (k < 5) @(posedge clk);
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.mem_ack_o === 1'b1) saw_ack = 1'b1;
        end
        rst = 1'b0;
        u_if.mem_enable_i = 1'b0;
        mdl_rd = 0; mdl_wr = 0; mdl_last = '0;
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(negedge clk);
            if (u_if.mem_ack_o === 1'b1) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack || u_if.busy_o !== 1'b0 || u_if.mem_data_o !== 256'd0) begin
            failures++;
            $display("FAIL rstmid abort: ack_seen=%b busy=%b data=%h expected 0 0 0",
                     saw_ack, u_if.busy_o, u_if.mem_data_o);
        end
        check_counts("rstmid");
        run_txn(1'b0, 32'h0000_0200, '0, 0, "rstmid_read_prior");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [31:0]  addr;
            logic [255:0] data;
            logic         wr;
            addr = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 15) << 5)
                 | $urandom_range(0, 31);
            data = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            wr = !mdl_valid[line_of(addr)] || ($urandom_range(0, 1) == 1);
            run_txn(wr, addr, data, (wr && $urandom_range(0, 1) == 1) ? 2 : 0, "random");
        end
    endtask

    initial begin
        u_if.mem_enable_i = 1'b0;
        u_if.mem_write_i  = 1'b0;
        u_if.mem_addr_i   = '0;
        u_if.mem_data_i   = '0;
        for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_enable_drop();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
